// File: rtl/ram_seq_ctrl_pkg.sv
// Shared constants, FSM encoding and size/alignment helpers for the byte-RAM sequencer.
package ram_pkg;

  localparam logic [1:0] BYTE       = 2'b00;
  localparam logic [1:0] HALFWORD   = 2'b01;
  localparam logic [1:0] WORD       = 2'b10;
  localparam logic [1:0] DOUBLEWORD = 2'b11;

  localparam logic WRITE = 1'b0;
  localparam logic READ  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic       rw;
    logic [1:0] typ;
  } req_t;

  // Index of the last byte of an access, i.e. N-1 for N = 1 << typ.
  function automatic logic [2:0] last_idx(input logic [1:0] typ);
    return 3'((4'd1 << typ) - 4'd1);
  endfunction

  function automatic logic misaligned(input logic [2:0] addr_lo, input logic [1:0] typ);
    return |(addr_lo & last_idx(typ));
  endfunction

endpackage

// File: rtl/ram_seq_ctrl_if.sv
// Request/done handshake between the load/store unit and the RAM sequencer.
interface ram_seq_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64
);
  logic              enable;
  logic              rw;
  logic [1:0]        type_data;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              mv;
  logic              busy;
  logic              err;

  modport master (
    output enable, rw, type_data, address, data_in,
    input  data_out, mv, busy, err
  );

  modport slave (
    input  enable, rw, type_data, address, data_in,
    output data_out, mv, busy, err
  );
endinterface

// File: rtl/ram_seq_ctrl_byte_array.sv
// Byte-wide storage: synchronous write, combinational read, contents never reset.
module ram_byte_array #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [7:0]        i_wdata,
  output logic [7:0]        o_rdata
);
  logic [7:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (i_we) mem[i_addr] <= i_wdata;
  end

  assign o_rdata = mem[i_addr];
endmodule

// File: rtl/ram_seq_ctrl.sv
// Byte-serial access sequencer: moves 1/2/4/8-byte big-endian requests one byte per clock.
module ram_seq_ctrl
  import ram_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64
) (
  input  logic     clk,
  input  logic     rst_n,
  ram_seq_if.slave bus
);
  state_t            r_state;
  req_t              r_req;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_dout;
  logic [2:0]        r_cnt;
  logic              r_busy;
  logic              r_mv;
  logic              r_err;

  logic [2:0]        w_nm1;
  logic [2:0]        w_idx;
  logic              w_last;
  logic [ADDR_W-1:0] w_maddr;
  logic              w_we;
  logic [7:0]        w_wbyte;
  logic [7:0]        w_rdata;
  logic [DATA_W-1:0] w_shift_nxt;

  assign w_nm1       = last_idx(r_req.typ);
  assign w_last      = (r_cnt == w_nm1);
  // Byte k of an N-byte access carries data bits [8*(N-k)-1 -: 8], MSB first.
  assign w_idx       = w_nm1 - r_cnt;
  assign w_wbyte     = r_data[{w_idx, 3'b000} +: 8];
  assign w_maddr     = r_addr + ADDR_W'(r_cnt);
  // Decoded from the async-reset state so a reset mid-transfer stops writes at once.
  assign w_we        = (r_state == S_XFER) && (r_req.rw == WRITE);
  assign w_shift_nxt = {r_shift[DATA_W-9:0], w_rdata};

  ram_byte_array #(.ADDR_W(ADDR_W)) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_maddr),
    .i_wdata (w_wbyte),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_req   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_shift <= '0;
      r_dout  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_mv    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.enable) begin
            r_req   <= '{rw: bus.rw, typ: bus.type_data};
            r_addr  <= bus.address;
            r_data  <= bus.data_in;
            r_shift <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            if (misaligned(bus.address[2:0], bus.type_data)) begin
              r_state <= S_DONE;
              r_err   <= 1'b1;
              r_mv    <= 1'b1;
            end else begin
              r_state <= S_XFER;
            end
          end
        end
        S_XFER: begin
          r_cnt <= r_cnt + 3'd1;
          if (r_req.rw == READ) r_shift <= w_shift_nxt;
          if (w_last) begin
            r_state <= S_DONE;
            r_mv    <= 1'b1;
            if (r_req.rw == READ) r_dout <= w_shift_nxt;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_mv    <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_mv    <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out = r_dout;
  assign bus.mv       = r_mv;
  assign bus.busy     = r_busy;
  assign bus.err      = r_err;
endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Scoreboard bench for ram_seq_ctrl: requests push expected completions, the mv monitor pops them.
module tb_ram_seq_ctrl;
  import ram_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_seq_if #(.ADDR_W(8), .DATA_W(64)) bus ();
  ram_seq_ctrl #(.ADDR_W(8), .DATA_W(64)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          lat;
    int          t0;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          mv_cnt = 0;
  int          busy_cnt = 0;
  logic [7:0]  tbmem [256];
  logic [63:0] last_rd = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (bus.busy === 1'b1) busy_cnt++;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.mv === 1'b1) begin
      mv_cnt++;
      if (sb.size() == 0) check("spurious_mv", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        check("data_out", bus.data_out, e.data);
        check("err", 64'(bus.err), 64'(e.err));
        check("latency", 64'(cyc - e.t0), 64'(e.lat));
      end
    end
  end

  task automatic req(input logic rw, input logic [1:0] t, input logic [7:0] a, input logic [63:0] d);
    int   n;
    logic mis;
    exp_t e;
    n   = 1 << t;
    mis = (int'(a) % n) != 0;
    @(negedge clk);
    bus.enable = 1'b1; bus.rw = rw; bus.type_data = t; bus.address = a; bus.data_in = d;
    if (!mis && rw == WRITE)
      for (int k = 0; k < n; k++) tbmem[8'(int'(a) + k)] = d[8*(n-1-k) +: 8];
    if (!mis && rw == READ) begin
      last_rd = '0;
      for (int k = 0; k < n; k++) last_rd = {last_rd[55:0], tbmem[8'(int'(a) + k)]};
    end
    e.data = last_rd; e.err = mis; e.lat = mis ? 1 : n + 1; e.t0 = cyc;
    sb.push_back(e);
    @(negedge clk);
    bus.enable = 1'b0; bus.data_in = ~d; bus.address = ~a; bus.rw = ~rw;
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      check("mv_timeout", 64'd1, 64'd0);
      sb.delete();
    end
  endtask

  task automatic check_mem(input string tag, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) check(tag, 64'(dut.u_mem.mem[i]), 64'(tbmem[i]));
  endtask

  initial begin
    int mv0;
    logic [63:0] dw;
    bus.enable = 1'b0; bus.rw = READ; bus.type_data = BYTE; bus.address = '0; bus.data_in = '0;
    for (int i = 0; i < 256; i++) begin
      tbmem[i] = 8'($urandom);
      dut.u_mem.mem[i] = tbmem[i];
    end
    #12;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_mv", 64'(bus.mv), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    check("rst_data_out", bus.data_out, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    req(WRITE, BYTE, 8'h00, 64'h9a);
    req(WRITE, BYTE, 8'h02, 64'h9b);
    req(READ,  BYTE, 8'h00, 64'h0);
    check("byte_rd0", bus.data_out, 64'h9a);
    req(READ,  BYTE, 8'h02, 64'h0);
    check("byte_rd2", bus.data_out, 64'h9b);

    req(WRITE, HALFWORD, 8'h00, 64'hbebe);
    check("hw_mem0", 64'(dut.u_mem.mem[0]), 64'hbe);
    check("hw_mem1", 64'(dut.u_mem.mem[1]), 64'hbe);
    req(READ, HALFWORD, 8'h00, 64'h0);
    check("hw_rd", bus.data_out, 64'h000000000000bebe);

    dw = 64'hcafefeafbebeabee;
    busy_cnt = 0;
    req(WRITE, DOUBLEWORD, 8'h08, dw);
    check("dw_busy_cycles", 64'(busy_cnt), 64'd9);
    for (int k = 0; k < 8; k++) check("dw_mem", 64'(dut.u_mem.mem[8+k]), 64'(dw[63-8*k -: 8]));
    req(READ, DOUBLEWORD, 8'h08, 64'h0);
    check("dw_rd", bus.data_out, dw);

    req(READ, WORD, 8'h04, 64'h0);
    req(WRITE, WORD, 8'h04, 64'h0badf00d);
    req(READ, WORD, 8'h04, 64'h0);
    check("word_rd", bus.data_out, 64'h0badf00d);

    req(READ, WORD, 8'h02, 64'h0);
    check("mis_keep_data", bus.data_out, 64'h0badf00d);
    req(WRITE, DOUBLEWORD, 8'h0c, 64'hffffffffffffffff);
    check_mem("mis_mem", 0, 8'h17);

    mv0 = mv_cnt;
    fork
      req(WRITE, WORD, 8'h20, 64'h01020304);
      begin
        repeat (2) @(negedge clk);
        #1; bus.enable = 1'b1; bus.address = 8'h40; bus.type_data = WORD;
        repeat (2) @(negedge clk);
        bus.enable = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    check("busy_ignore_mv_count", 64'(mv_cnt - mv0), 64'd1);
    check_mem("busy_ignore_mem", 8'h20, 8'h43);

    mv0 = mv_cnt;
    dw = 64'h1122334455667788;
    @(negedge clk);
    bus.enable = 1'b1; bus.rw = WRITE; bus.type_data = DOUBLEWORD; bus.address = 8'h10; bus.data_in = dw;
    @(negedge clk);
    bus.enable = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 64'(bus.busy), 64'd0);
    check("rst_mid_mv", 64'(bus.mv), 64'd0);
    check("rst_mid_err", 64'(bus.err), 64'd0);
    check("rst_mid_data_out", bus.data_out, 64'd0);
    last_rd = '0;
    tbmem[8'h10] = 8'h11; tbmem[8'h11] = 8'h22; tbmem[8'h12] = 8'h33;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_mem("rst_mid_mem", 8'h10, 8'h17);
    check("rst_mid_no_mv", 64'(mv_cnt - mv0), 64'd0);

    req(READ, WORD, 8'h10, 64'h0);
    check("post_rst_rd", bus.data_out[31:8], 64'h112233);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
